mul_sequencer: RTL and testbench

Multi-cycle multiply controller for the single-cycle ARM core's execute stage, serving the UMUL and SMUL instructions. It latches two 32-bit operands on a start request and runs a radix-2 shift-add multiply over several cycles. While busy it stalls the rest of the datapath, then returns a 64-bit product and a one-cycle completion pulse. It sits beside the ALU; the control unit drives Start and MCycleOp, and the hazard/stall logic consumes Busy.

---
 rtl/mul_sequencer_if.sv | 23 ++
 rtl/mul_sequencer.sv | 128 ++++++++++++
 tb/tb_mul_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// Request/response bundle between the execute-stage control and the multi-cycle multiplier.
interface mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy, Done
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy, Done
    );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiplier (UMUL/SMUL) with stall and done handshake.
// Optional MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic           CLK,
    input  logic           RESET,
    mul_sequencer_if.slave mb
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   sum;
    logic                 last_iter;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        // The most negative value negates to itself, which is its correct unsigned magnitude.
        return (is_signed && sv < 0) ? WIDTH'(-sv) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p, input logic neg);
        return neg ? (~p + 1'b1) : p;
    endfunction

    assign sum = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef MUL_EARLY_TERM_EN
    assign last_iter = (cnt_q == LAST_CNT) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign last_iter = (cnt_q == LAST_CNT);
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (mb.Start) state_d = S_COMPUTE;
            S_COMPUTE: if (last_iter) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mb.Busy = 1'b0;
        mb.Done = 1'b0;
        unique case (state_q)
            S_IDLE:    mb.Busy = mb.Start;
            S_COMPUTE: mb.Busy = 1'b1;
            S_DONE:    mb.Done = 1'b1;
            default:   ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        res_d    = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (mb.Start) begin
                    mcand_d  = {{WIDTH{1'b0}}, magnitude(mb.Operand1, mb.MCycleOp)};
                    mplier_d = magnitude(mb.Operand2, mb.MCycleOp);
                    neg_d    = mb.MCycleOp & (mb.Operand1[WIDTH-1] ^ mb.Operand2[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_COMPUTE: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) res_d = apply_sign(sum, neg_q);
            end
            default: ;
        endcase
    end

    // Datapath registers; an abandoned operation leaves zeroed results
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            res_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            res_q    <= res_d;
        end
    end

    assign mb.Result1 = res_q[WIDTH-1:0];
    assign mb.Result2 = res_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: products, latency, handshake, reset behaviour.
module tb_mul_sequencer;
    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    mul_sequencer_if #(.WIDTH(32)) mif ();

    mul_sequencer #(.WIDTH(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .mb    (mif.slave)
    );

`ifdef MUL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int bound, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int c = 1; c <= bound && !ok; c++) begin
            @(negedge CLK);
            cyc = c;
            if (mif.Done) ok = 1'b1;
        end
    endtask

    task automatic run_mul(input string tag, input logic op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] prod, input int lat_early);
        int busy_n;
        int lat;
        bit seen;
        lat = EARLY ? lat_early : 33;
        @(negedge CLK);
        mif.Start    = 1'b1;
        mif.MCycleOp = op;
        mif.Operand1 = a;
        mif.Operand2 = b;
        #1 chk({tag, ".busy_c0"}, 64'(mif.Busy), 64'd1);
        busy_n = 1;
        seen   = 1'b0;
        @(posedge CLK);
        #1;
        mif.Start    = 1'b0;
        mif.MCycleOp = ~op;
        mif.Operand1 = 32'hDEAD_BEEF;
        mif.Operand2 = 32'h5A5A_A5A5;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge CLK);
            if (mif.Busy) busy_n++;
            if (mif.Done) begin
                seen = 1'b1;
                chk({tag, ".busy_in_done"}, 64'(mif.Busy), 64'd0);
                chk({tag, ".product"}, {mif.Result2, mif.Result1}, prod);
                chk({tag, ".done_cycle"}, 64'(c), 64'(lat));
            end
        end
        chk({tag, ".done_seen"}, 64'(seen), 64'd1);
        chk({tag, ".busy_cycles"}, 64'(busy_n), 64'(lat));
        @(negedge CLK);
        chk({tag, ".done_single"}, 64'(mif.Done), 64'd0);
        chk({tag, ".hold"}, {mif.Result2, mif.Result1}, prod);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int cyc;
        int rst_cyc;
        int dn;

        RESET        = 1'b1;
        mif.Start    = 1'b0;
        mif.MCycleOp = 1'b0;
        mif.Operand1 = '0;
        mif.Operand2 = '0;
        repeat (3) @(negedge CLK);
        chk("reset.busy", 64'(mif.Busy), 64'd0);
        chk("reset.done", 64'(mif.Done), 64'd0);
        chk("reset.result", {mif.Result2, mif.Result1}, 64'd0);
        RESET = 1'b0;

        run_mul("umul_ff_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);
        run_mul("smul_m1_2",  1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 3);
        run_mul("umul_ff_2",  1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 3);
        run_mul("smul_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33);
        run_mul("smul_min_1", 1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 2);
        run_mul("umul_ff_1",  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 2);
        run_mul("umul_x_0",   1'b0, 32'h1234_5678, 32'h0000_0000, 64'h0, 2);
        run_mul("smul_7_m3",  1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 3);

        // Back-to-back with Start held high
        @(negedge CLK);
        mif.Start    = 1'b1;
        mif.MCycleOp = 1'b0;
        mif.Operand1 = 32'd3;
        mif.Operand2 = 32'd5;
        @(posedge CLK);
        #1;
        mif.Operand1 = 32'd7;
        mif.Operand2 = 32'd6;
        wait_done(40, ok, cyc);
        chk("b2b.first_done_seen", 64'(ok), 64'd1);
        chk("b2b.first_r1", 64'(mif.Result1), 64'd15);
        chk("b2b.first_busy_low", 64'(mif.Busy), 64'd0);
        @(negedge CLK);
        chk("b2b.restart_busy", 64'(mif.Busy), 64'd1);
        chk("b2b.restart_r1", 64'(mif.Result1), 64'd15);
        @(negedge CLK);
        chk("b2b.mid_busy", 64'(mif.Busy), 64'd1);
        chk("b2b.mid_r1", 64'(mif.Result1), 64'd15);
        wait_done(40, ok, cyc);
        chk("b2b.second_done_seen", 64'(ok), 64'd1);
        chk("b2b.second_r1", 64'(mif.Result1), 64'd42);
        chk("b2b.second_busy_low", 64'(mif.Busy), 64'd0);
        mif.Start = 1'b0;
        @(negedge CLK);
        chk("b2b.idle_busy", 64'(mif.Busy), 64'd0);
        chk("b2b.idle_r1", 64'(mif.Result1), 64'd42);

        // Reset in the middle of an operation
        rst_cyc = EARLY ? 3 : 10;
        @(negedge CLK);
        mif.Start    = 1'b1;
        mif.MCycleOp = 1'b0;
        mif.Operand1 = 32'h0000_1234;
        mif.Operand2 = 32'h0000_0010;
        @(posedge CLK);
        #1 mif.Start = 1'b0;
        repeat (rst_cyc) @(negedge CLK);
        chk("rst_mid.busy_before", 64'(mif.Busy), 64'd1);
        RESET = 1'b1;
        @(negedge CLK);
        chk("rst_mid.busy", 64'(mif.Busy), 64'd0);
        chk("rst_mid.done", 64'(mif.Done), 64'd0);
        chk("rst_mid.result", {mif.Result2, mif.Result1}, 64'd0);
        RESET = 1'b0;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (mif.Done) dn++;
        end
        chk("rst_mid.no_done", 64'(dn), 64'd0);

        // Reset wins over Start in the same cycle
        @(negedge CLK);
        RESET        = 1'b1;
        mif.Start    = 1'b1;
        mif.Operand1 = 32'd3;
        mif.Operand2 = 32'd5;
        @(negedge CLK);
        RESET     = 1'b0;
        mif.Start = 1'b0;
        #1;
        chk("rst_prio.busy", 64'(mif.Busy), 64'd0);
        chk("rst_prio.done", 64'(mif.Done), 64'd0);
        chk("rst_prio.result", {mif.Result2, mif.Result1}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
